// File: rtl/mips_run_controller.sv
// Run/step/breakpoint sequencer that gates a single-cycle MIPS core and selects the display index.
// Define RUN_CTRL_BREAKPOINT_EN to build the PC-breakpoint stop (BREAK state) and its skip flag.
module mips_run_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] RUN_DIV         = 32'd1,
  parameter logic [31:0] SCAN_CYCLES     = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        run_btn,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic [4:0]  sel_sw,
  input  logic        auto_scan,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] instr_count,
  output logic [4:0]  disp_sel
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_STEP  = 2'b01,
    S_RUN   = 2'b10,
    S_BREAK = 2'b11
  } run_state_t;

  run_state_t  cur;
  logic [1:0]  btn_raw;
  logic [1:0]  sync_a;
  logic [1:0]  sync_b;
  logic [1:0]  level;
  logic [1:0]  level_q;
  logic [15:0] db_cnt [2];
  logic [1:0]  press;
  logic        step_press;
  logic        run_press;
  logic [31:0] div_cnt;
  logic        div_tick;
  logic        bp_hit;
  logic [31:0] scan_cnt;

  assign btn_raw = {run_btn, step_btn};

  // Bit 0 = step, bit 1 = run: 2-FF synchroniser, then level accepted after N equal samples
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a    <= 2'b00;
      sync_b    <= 2'b00;
      level     <= 2'b00;
      level_q   <= 2'b00;
      db_cnt[0] <= 16'd0;
      db_cnt[1] <= 16'd0;
    end else begin
      sync_a  <= btn_raw;
      sync_b  <= sync_a;
      level_q <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= 16'd0;
        end else if (db_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          db_cnt[i] <= 16'd0;
          level[i]  <= sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign press      = level & ~level_q;
  assign run_press  = press[1];
  assign step_press = press[0] & ~press[1];

  assign div_tick = (div_cnt == RUN_DIV - 32'd1);

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic skip;

  assign bp_hit = (pc == bp_addr) && !skip;

  // Leaving BREAK lets the trapped instruction retire once before the compare re-arms
  always_ff @(posedge clk) begin
    if (reset) begin
      skip <= 1'b0;
    end else if ((cur == S_BREAK) && (run_press || step_press)) begin
      skip <= 1'b1;
    end else if (cpu_en) begin
      skip <= 1'b0;
    end
  end
`else
  logic unused_bp;

  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_addr};
`endif

  assign cpu_en = (cur == S_STEP) || ((cur == S_RUN) && div_tick && !bp_hit);
  assign state  = cur;

  // Sequencer; run press beats step press and beats a breakpoint hit
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_HALT;
      halted  <= 1'b1;
      div_cnt <= 32'd0;
    end else begin
      case (cur)
        S_HALT: begin
          if (run_press) begin
            cur     <= S_RUN;
            halted  <= 1'b0;
            div_cnt <= 32'd0;
          end else if (step_press) begin
            cur    <= S_STEP;
            halted <= 1'b0;
          end
        end
        S_STEP: begin
          cur    <= S_HALT;
          halted <= 1'b1;
        end
        S_RUN: begin
          if (run_press) begin
            cur    <= S_HALT;
            halted <= 1'b1;
          end else if (bp_hit) begin
            cur    <= S_BREAK;
            halted <= 1'b1;
          end else begin
            div_cnt <= div_tick ? 32'd0 : div_cnt + 32'd1;
          end
        end
        S_BREAK: begin
          if (run_press) begin
            cur     <= S_RUN;
            halted  <= 1'b0;
            div_cnt <= 32'd0;
          end else if (step_press) begin
            cur    <= S_STEP;
            halted <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= 32'd0;
    end else if (cpu_en) begin
      instr_count <= instr_count + 32'd1;
    end
  end

  // Auto-scan continues from whatever index is currently shown
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_sel <= 5'd0;
      scan_cnt <= 32'd0;
    end else if (!auto_scan) begin
      disp_sel <= sel_sw;
      scan_cnt <= 32'd0;
    end else if (scan_cnt == SCAN_CYCLES - 32'd1) begin
      disp_sel <= disp_sel + 5'd1;
      scan_cnt <= 32'd0;
    end else begin
      scan_cnt <= scan_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips_run_controller.sv
// Scoreboard bench for mips_run_controller (DEBOUNCE_CYCLES=4, RUN_DIV=2, SCAN_CYCLES=3).
module tb_mips_run_controller;

  localparam int K_STATE   = 0;
  localparam int K_CPU_EN  = 1;
  localparam int K_HALTED  = 2;
  localparam int K_COUNT   = 3;
  localparam int K_DISP    = 4;
  localparam int K_PENDING = 5;
  localparam int K_BREAK   = 6;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
  } pulse_t;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_btn = 1'b0;
  logic        run_btn = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] bp_addr = 32'h0000000C;
  logic [4:0]  sel_sw = 5'd0;
  logic        auto_scan = 1'b0;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] instr_count;
  logic [4:0]  disp_sel;
  logic        pc_clr = 1'b1;

  pulse_t pulse_q[$];
  snap_t  snap_q[$];
  int     nvec = 0;
  int     nfail = 0;
  bit     seen_break = 1'b0;

  mips_run_controller #(
    .DEBOUNCE_CYCLES(16'd4),
    .RUN_DIV(32'd2),
    .SCAN_CYCLES(32'd3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step_btn(step_btn),
    .run_btn(run_btn),
    .pc(pc),
    .bp_addr(bp_addr),
    .sel_sw(sel_sw),
    .auto_scan(auto_scan),
    .cpu_en(cpu_en),
    .state(state),
    .halted(halted),
    .instr_count(instr_count),
    .disp_sel(disp_sel)
  );

  always #5 clk = ~clk;

  // Core model: PC advances one word per enabled cycle
  always @(posedge clk) begin
    if (pc_clr) pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every cpu_en cycle retires the next expected instruction; snapshots checked at the same edge
  always @(negedge clk) begin
    pulse_t      p;
    snap_t       s;
    logic [31:0] act;
    if (state === 2'b11) seen_break = 1'b1;
    if (cpu_en === 1'b1) begin
      if (pulse_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_pulse: cpu_en=1 at pc=0x%08h instr_count=%0d, required cpu_en=0", pc, instr_count);
      end else begin
        p = pulse_q.pop_front();
        cmp("pulse_pc", pc, p.pc);
        cmp("pulse_count", instr_count, p.cnt);
      end
    end
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      case (s.kind)
        K_STATE:   act = {30'd0, state};
        K_CPU_EN:  act = {31'd0, cpu_en};
        K_HALTED:  act = {31'd0, halted};
        K_COUNT:   act = instr_count;
        K_DISP:    act = {27'd0, disp_sel};
        K_PENDING: act = 32'(pulse_q.size());
        default:   act = {31'd0, seen_break};
      endcase
      cmp(s.name, act, s.exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap(input int kind, input string name, input logic [31:0] exp);
    snap_t s;
    s.kind = kind;
    s.name = name;
    s.exp  = exp;
    snap_q.push_back(s);
  endtask

  task automatic expect_pulses(input logic [31:0] pc0, input logic [31:0] cnt0, input int n);
    pulse_t p;
    for (int k = 0; k < n; k++) begin
      p.pc  = pc0 + 32'(4 * k);
      p.cnt = cnt0 + 32'(k);
      pulse_q.push_back(p);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    pc_clr = 1'b1;
    tick(2);
    reset  = 1'b0;
    pc_clr = 1'b0;
  endtask

  // Held for six edges so the debouncer sees four equal samples
  task automatic press_run();
    @(posedge clk);
    #1 run_btn = 1'b1;
    repeat (6) @(posedge clk);
    #1 run_btn = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    snap(K_STATE, "reset_state", 32'd0);
    snap(K_CPU_EN, "reset_cpu_en", 32'd0);
    snap(K_HALTED, "reset_halted", 32'd1);
    snap(K_COUNT, "reset_count", 32'd0);
    snap(K_DISP, "reset_disp", 32'd0);

    // Single step: one long press gives exactly one enable
    do_reset();
    expect_pulses(32'd0, 32'd0, 1);
    @(posedge clk);
    #1 step_btn = 1'b1;
    tick(10);
    step_btn = 1'b0;
    tick(10);
    snap(K_STATE, "step_state", 32'd0);
    snap(K_HALTED, "step_halted", 32'd1);
    snap(K_COUNT, "step_count", 32'd1);
    snap(K_PENDING, "step_pending", 32'd0);

    // Bouncing step button never settles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step_btn = ~step_btn;
      tick(2);
    end
    tick(10);
    snap(K_STATE, "bounce_state", 32'd0);
    snap(K_COUNT, "bounce_count", 32'd0);

    // Free run at every 2nd cycle, then halt: ten enables fall between the two presses
    do_reset();
    expect_pulses(32'd0, 32'd0, 10);
    press_run();
    tick(14);
    snap(K_STATE, "run_state", 32'd2);
    snap(K_HALTED, "run_halted", 32'd0);
    press_run();
    tick(10);
    snap(K_STATE, "run_stop_state", 32'd0);
    snap(K_HALTED, "run_stop_halted", 32'd1);
    snap(K_CPU_EN, "run_stop_cpu_en", 32'd0);
    snap(K_COUNT, "run_count", 32'd10);
    snap(K_PENDING, "run_pending", 32'd0);

    // Breakpoint at 0x0C
    do_reset();
`ifdef RUN_CTRL_BREAKPOINT_EN
    expect_pulses(32'd0, 32'd0, 3);
    press_run();
    tick(14);
    snap(K_STATE, "bp_break_state", 32'd3);
    snap(K_HALTED, "bp_break_halted", 32'd1);
    snap(K_CPU_EN, "bp_break_cpu_en", 32'd0);
    snap(K_COUNT, "bp_break_count", 32'd3);
    snap(K_PENDING, "bp_break_pending", 32'd0);
    expect_pulses(32'h0000000C, 32'd3, 10);
    press_run();
    tick(14);
    snap(K_STATE, "bp_resume_state", 32'd2);
    press_run();
    tick(10);
    snap(K_STATE, "bp_stop_state", 32'd0);
    snap(K_COUNT, "bp_count", 32'd13);
    snap(K_PENDING, "bp_pending", 32'd0);
`else
    expect_pulses(32'd0, 32'd0, 10);
    press_run();
    tick(14);
    snap(K_STATE, "nobp_state", 32'd2);
    press_run();
    tick(10);
    snap(K_STATE, "nobp_stop_state", 32'd0);
    snap(K_COUNT, "nobp_count", 32'd10);
    snap(K_PENDING, "nobp_pending", 32'd0);
    snap(K_BREAK, "nobp_never_break", 32'd0);
`endif

    // Display index: scan wraps 30 -> 31 -> 0, then manual select follows sel_sw
    do_reset();
    sel_sw = 5'd30;
    tick(2);
    auto_scan = 1'b1;
    tick(2);
    snap(K_DISP, "scan_hold30", 32'd30);
    tick(1);
    snap(K_DISP, "scan_to31", 32'd31);
    tick(2);
    snap(K_DISP, "scan_hold31", 32'd31);
    tick(1);
    snap(K_DISP, "scan_wrap0", 32'd0);
    tick(1);
    auto_scan = 1'b0;
    sel_sw    = 5'd5;
    snap(K_DISP, "manual_latency", 32'd0);
    tick(1);
    snap(K_DISP, "manual_sel5", 32'd5);

    // Reset while running
    do_reset();
    expect_pulses(32'd0, 32'd0, 3);
    press_run();
    tick(6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    snap(K_STATE, "midrun_reset_state", 32'd0);
    snap(K_CPU_EN, "midrun_reset_cpu_en", 32'd0);
    snap(K_COUNT, "midrun_reset_count", 32'd0);
    snap(K_PENDING, "midrun_reset_pending", 32'd0);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
